regfile_sb: RTL
===============

Name: regfile_sb

Overview:
Parametrised register file for the decode stage, the successor to the single-write-port 32x32 file. It provides configurable data width and depth, two write ports (ALU writeback and load writeback) and write-to-read bypass. An optional hardwired-zero register 0 is supported. An integrated busy-bit scoreboard reports, per read port, whether the operand is still awaiting a pending writeback, so decode can stall.

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never busy
BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all registers and busy bits
raddr1  in  ADDR_W  read port 1 address
raddr2  in  ADDR_W  read port 2 address
rdata1  out  DATA_W  read port 1 data, combinational
rdata2  out  DATA_W  read port 2 data, combinational
rbusy1  out  1  register at raddr1 has a pending write not yet satisfied this cycle
rbusy2  out  1  same for raddr2
w0_en  in  1  write port 0 (ALU writeback) enable
w0_addr  in  ADDR_W  write port 0 address
w0_data  in  DATA_W  write port 0 data
w1_en  in  1  write port 1 (load writeback) enable
w1_addr  in  ADDR_W  write port 1 address
w1_data  in  DATA_W  write port 1 data
iss_en  in  1  issue: mark iss_addr busy (new producer in flight)
iss_addr  in  ADDR_W  destination register of issued instruction
flush  in  1  clear all busy bits (pipeline flush); register contents untouched
any_busy  out  1  OR of all busy bits, registered state

Behaviour:
- Reset (clk, synchronous, active-high): all registers = 0, all busy = 0. During and after reset: rdata* = 0 (register contents), rbusy* = 0, any_busy = 0. Reset overrides every other input in the same cycle.
- Write: on posedge, when wN_en is set, reg[wN_addr] <= wN_data. If w0 and w1 target the same address in one cycle, w1 wins.
- ZERO_REG=1: writes to address 0 are discarded, rdata reads 0 for address 0, busy[0] is never set, rbusy reads 0 for address 0.
- Read, BYPASS=1: if w1_en and w1_addr==raddr, rdata = w1_data; else if w0_en and w0_addr==raddr, rdata = w0_data; else rdata = stored value. Zero-register rule applies first. BYPASS=0: rdata = stored value only (new data visible the cycle after the write).
- Scoreboard, per-register busy bit, next-state priority: reset > flush > iss_en set > write clear.
  - A write on port 0 or 1 clears busy[addr].
  - iss_en to the same address as a same-cycle write leaves busy=1 (the newer producer wins).
  - flush with iss_en in the same cycle: all bits clear, and the issue is dropped.
- rbusyN = busy[raddrN] AND NOT (BYPASS AND a same-cycle write to raddrN). With BYPASS=0, rbusyN = busy[raddrN].
- any_busy reflects current busy state (pre-edge); it does not include same-cycle iss_en.
- Latency: write-to-read is 0 cycles with BYPASS, otherwise 1 cycle. Issue-to-busy is 1 cycle.
- Widths: no arithmetic. Addresses are full range 0..2**ADDR_W-1 with no out-of-range case.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults and the register-index constant for the zero register, reused by decode, hazard and forwarding logic.
- One natural sub-module: regfile_scoreboard, holding the busy-bit vector with set/clear/flush priority and producing rbusy1/rbusy2/any_busy. Storage and bypass muxing stay in the top.

Test Plan:
- Reset, then read every address on both ports -> rdata1=rdata2=0, rbusy*=0, any_busy=0.
- w0_en, addr 5, data 0xDEADBEEF; same cycle raddr1=5 -> rdata1=0xDEADBEEF (bypass); next cycle with w0_en=0 -> still 0xDEADBEEF. With BYPASS=0, rdata1 shows the old value 0 in the write cycle.
- w0 (addr 7, 0x11) and w1 (addr 7, 0x22) in the same cycle -> rdata on addr 7 = 0x22 that cycle and after.
- Write 0xFFFFFFFF to addr 0 with ZERO_REG=1, then iss_en to addr 0 -> rdata=0, rbusy=0, any_busy=0.
- iss_en addr 3 -> next cycle rbusy1=1, any_busy=1. Then w1 to addr 3 with data 0x42 -> that cycle rbusy1=0 and rdata1=0x42; next cycle busy cleared. Repeat with iss_en and w0 to addr 3 in the same cycle -> busy remains 1.
- Issue addrs 4 and 9, then assert flush together with iss_en addr 10 -> next cycle all busy=0, any_busy=0, register contents unchanged. Assert reset mid-operation with busy bits set and pending writes -> all state 0 next cycle.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the decode-stage register file and scoreboard.
// Decode, hazard and forwarding logic reuse these defaults and the zero-register index.
package regfile_sb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_IDX   = 0;

  // Per-register busy-bit action chosen for the coming edge.
  typedef enum logic [1:0] {
    BUSY_HOLD  = 2'd0,
    BUSY_CLEAR = 2'd1,
    BUSY_SET   = 2'd2,
    BUSY_FLUSH = 2'd3
  } busy_op_e;

  function automatic bit is_zero_idx(input int idx, input bit zero_en);
    return zero_en && (idx == ZERO_IDX);
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode-side bus of the register file: two read ports, two writeback ports, issue and flush.
// Every *_en / flush strobe acts on the rising clk edge it is high at; there is no back-pressure.
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              rbusy1;
  logic              rbusy2;

  logic              w0_en;
  logic [ADDR_W-1:0] w0_addr;
  logic [DATA_W-1:0] w0_data;
  logic              w1_en;
  logic [ADDR_W-1:0] w1_addr;
  logic [DATA_W-1:0] w1_data;

  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic              flush;
  logic              any_busy;

  modport master (
    output raddr1, raddr2,
    output w0_en, w0_addr, w0_data,
    output w1_en, w1_addr, w1_data,
    output iss_en, iss_addr, flush,
    input  rdata1, rdata2, rbusy1, rbusy2, any_busy
  );

  modport slave (
    input  raddr1, raddr2,
    input  w0_en, w0_addr, w0_data,
    input  w1_en, w1_addr, w1_data,
    input  iss_en, iss_addr, flush,
    output rdata1, rdata2, rbusy1, rbusy2, any_busy
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set on issue, cleared by writeback, wiped by flush.
// Reports per-read-port pending status and a registered any-busy summary.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_flush,
  input  logic              i_iss_en,
  input  logic [ADDR_W-1:0] i_iss_addr,
  input  logic              i_w0_en,
  input  logic [ADDR_W-1:0] i_w0_addr,
  input  logic              i_w1_en,
  input  logic [ADDR_W-1:0] i_w1_addr,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic              o_rbusy1,
  output logic              o_rbusy2,
  output logic              o_any_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  busy_op_e         w_op [DEPTH];
  logic             w_hit1;
  logic             w_hit2;

  // A newly issued producer outranks a writeback retiring the older one.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_op[i] = BUSY_HOLD;
      if (i_flush) begin
        w_op[i] = BUSY_FLUSH;
      end else if (i_iss_en && (i_iss_addr == ADDR_W'(i))) begin
        w_op[i] = BUSY_SET;
      end else if ((i_w0_en && (i_w0_addr == ADDR_W'(i))) ||
                   (i_w1_en && (i_w1_addr == ADDR_W'(i)))) begin
        w_op[i] = BUSY_CLEAR;
      end
    end
  end

  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < DEPTH; i++) begin
      case (w_op[i])
        BUSY_SET:   w_busy_nxt[i] = 1'b1;
        BUSY_CLEAR: w_busy_nxt[i] = 1'b0;
        BUSY_FLUSH: w_busy_nxt[i] = 1'b0;
        default:    w_busy_nxt[i] = r_busy[i];
      endcase
      if (is_zero_idx(i, ZERO_REG)) begin
        w_busy_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign w_hit1 = (i_w0_en && (i_w0_addr == i_raddr1)) ||
                  (i_w1_en && (i_w1_addr == i_raddr1));
  assign w_hit2 = (i_w0_en && (i_w0_addr == i_raddr2)) ||
                  (i_w1_en && (i_w1_addr == i_raddr2));

  // With forwarding, the writeback landing this cycle already satisfies the operand.
  assign o_rbusy1   = r_busy[i_raddr1] && !(BYPASS && w_hit1);
  assign o_rbusy2   = r_busy[i_raddr2] && !(BYPASS && w_hit2);
  assign o_any_busy = |r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Decode-stage register file: two writeback ports (w1 wins on collision), optional
// write-to-read forwarding, optional hardwired-zero r0, and an integrated busy scoreboard.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];

  logic              w_w0_ok;
  logic              w_w1_ok;
  logic [ADDR_W-1:0] w_raddr [2];
  logic [DATA_W-1:0] w_rdata [2];

  assign w_w0_ok = bus.w0_en && !is_zero_idx(int'(bus.w0_addr), ZERO_REG);
  assign w_w1_ok = bus.w1_en && !is_zero_idx(int'(bus.w1_addr), ZERO_REG);

  // The w1 assignment comes last so the load writeback wins an address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_w0_ok) begin
        r_regs[bus.w0_addr] <= bus.w0_data;
      end
      if (w_w1_ok) begin
        r_regs[bus.w1_addr] <= bus.w1_data;
      end
    end
  end

  assign w_raddr[0] = bus.raddr1;
  assign w_raddr[1] = bus.raddr2;

  // Zero-register masking is applied last so it overrides any forwarded value.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rdata[p] = r_regs[w_raddr[p]];
      if (BYPASS) begin
        if (bus.w1_en && (bus.w1_addr == w_raddr[p])) begin
          w_rdata[p] = bus.w1_data;
        end else if (bus.w0_en && (bus.w0_addr == w_raddr[p])) begin
          w_rdata[p] = bus.w0_data;
        end
      end
      if (is_zero_idx(int'(w_raddr[p]), ZERO_REG)) begin
        w_rdata[p] = '0;
      end
    end
  end

  assign bus.rdata1 = w_rdata[0];
  assign bus.rdata2 = w_rdata[1];

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (bus.flush),
    .i_iss_en   (bus.iss_en),
    .i_iss_addr (bus.iss_addr),
    .i_w0_en    (bus.w0_en),
    .i_w0_addr  (bus.w0_addr),
    .i_w1_en    (bus.w1_en),
    .i_w1_addr  (bus.w1_addr),
    .i_raddr1   (bus.raddr1),
    .i_raddr2   (bus.raddr2),
    .o_rbusy1   (bus.rbusy1),
    .o_rbusy2   (bus.rbusy2),
    .o_any_busy (bus.any_busy)
  );

endmodule
